// File: rtl/gb_cpu_decoder.sv
// SM83 instruction decoder: turns the current opcode, CB-prefix flag and ISR request
// into a registered micro-schedule consumed by the CPU sequencer.

package gb_cpu_common_pkg;

   typedef enum logic [3:0] {
      ALU_NOP   = 4'd0,
      ALU_ADD   = 4'd1,
      ALU_ADC   = 4'd2,
      ALU_SUB   = 4'd3,
      ALU_SBC   = 4'd4,
      ALU_AND   = 4'd5,
      ALU_XOR   = 4'd6,
      ALU_OR    = 4'd7,
      ALU_CP    = 4'd8,
      ALU_INC   = 4'd9,
      ALU_DEC   = 4'd10,
      ALU_ADD16 = 4'd11,
      ALU_INC16 = 4'd12,
      ALU_DEC16 = 4'd13,
      ALU_ADDSP = 4'd14,
      ALU_CB    = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic [2:0] m_cycles;
      alu_op_e    alu_op;
      logic [2:0] src;
      logic [2:0] dst;
      logic [1:0] rr;
      logic [1:0] cb_op;
      logic [2:0] cb_bit;
      logic       mem_rd;
      logic       mem_wr;
      logic       imm8;
      logic       is_cb;
      logic       is_isr;
      logic       halt;
      logic       unsupported;
   } schedule_t;

   localparam logic [2:0] REG_HL = 3'd6;
   localparam logic [2:0] REG_A  = 3'd7;
   localparam logic [1:0] RR_SP  = 2'd3;
   localparam logic [1:0] CB_BIT = 2'd1;

   localparam schedule_t SCHEDULE_RESET = schedule_t'({3'd1, 24'd0});

endpackage

module gb_cpu_decoder
   import gb_cpu_common_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic [7:0] opcode,
   input  logic      cb_prefix,
   input  logic      isr_cmd,
   output schedule_t schedule
);

   schedule_t  decoded;
   logic [2:0] r_hi;
   logic [2:0] r_lo;
   logic [1:0] rr_sel;

   assign r_hi   = opcode[5:3];
   assign r_lo   = opcode[2:0];
   assign rr_sel = opcode[5:4];

   always_comb begin
      // NOTE: every field gets a default first so no path through the case tree infers a latch.
      decoded          = '0;
      decoded.m_cycles = 3'd1;

      if (isr_cmd) begin
         decoded.m_cycles = 3'd5;
         decoded.mem_wr   = 1'b1;
         decoded.is_isr   = 1'b1;
         decoded.rr       = RR_SP;
      end else if (cb_prefix) begin
         decoded.alu_op = ALU_CB;
         decoded.is_cb  = 1'b1;
         decoded.cb_op  = opcode[7:6];
         decoded.cb_bit = r_hi;
         decoded.src    = r_lo;
         decoded.dst    = r_lo;
         if (r_lo == REG_HL) begin
            decoded.mem_rd = 1'b1;
            if (opcode[7:6] == CB_BIT) begin
               decoded.m_cycles = 3'd2;
            end else begin
               decoded.m_cycles = 3'd3;
               decoded.mem_wr   = 1'b1;
            end
         end
      end else begin
         unique case (opcode[7:6])
            2'b00: begin
               if (opcode != 8'h00) begin
                  case (r_lo)
                     3'b100, 3'b101: begin
                        decoded.alu_op = opcode[0] ? ALU_DEC : ALU_INC;
                        decoded.src    = r_hi;
                        decoded.dst    = r_hi;
                        if (r_hi == REG_HL) begin
                           decoded.m_cycles = 3'd3;
                           decoded.mem_rd   = 1'b1;
                           decoded.mem_wr   = 1'b1;
                        end
                     end
                     3'b011: begin
                        decoded.m_cycles = 3'd2;
                        decoded.alu_op   = opcode[3] ? ALU_DEC16 : ALU_INC16;
                        decoded.rr       = rr_sel;
                     end
                     3'b001: begin
                        // Only ADD HL,rr lives here; LD rr,nn is outside this decoder's scope.
                        if (opcode[3]) begin
                           decoded.m_cycles = 3'd2;
                           decoded.alu_op   = ALU_ADD16;
                           decoded.rr       = rr_sel;
                        end else begin
                           decoded.unsupported = 1'b1;
                        end
                     end
                     3'b110: begin
                        decoded.imm8 = 1'b1;
                        decoded.dst  = r_hi;
                        if (r_hi == REG_HL) begin
                           decoded.m_cycles = 3'd3;
                           decoded.mem_wr   = 1'b1;
                        end else begin
                           decoded.m_cycles = 3'd2;
                        end
                     end
                     default: decoded.unsupported = 1'b1;
                  endcase
               end
            end
            2'b01: begin
               if (opcode == 8'h76) begin
                  decoded.halt = 1'b1;
               end else begin
                  decoded.dst    = r_hi;
                  decoded.src    = r_lo;
                  decoded.mem_rd = (r_lo == REG_HL);
                  decoded.mem_wr = (r_hi == REG_HL);
                  if ((r_lo == REG_HL) || (r_hi == REG_HL)) decoded.m_cycles = 3'd2;
               end
            end
            2'b10: begin
               decoded.alu_op = alu_op_e'({1'b0, r_hi} + 4'd1);
               decoded.dst    = REG_A;
               decoded.src    = r_lo;
               if (r_lo == REG_HL) begin
                  decoded.m_cycles = 3'd2;
                  decoded.mem_rd   = 1'b1;
               end
            end
            2'b11: begin
               if (r_lo == 3'b110) begin
                  decoded.alu_op   = alu_op_e'({1'b0, r_hi} + 4'd1);
                  decoded.dst      = REG_A;
                  decoded.m_cycles = 3'd2;
                  decoded.imm8     = 1'b1;
               end else if (opcode == 8'hE8) begin
                  decoded.m_cycles = 3'd4;
                  decoded.alu_op   = ALU_ADDSP;
                  decoded.rr       = RR_SP;
                  decoded.imm8     = 1'b1;
               end else begin
                  decoded.unsupported = 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: the reset branch sits in the same always_ff as the clocked update, so an
   // asserted rst_n overrides the schedule immediately rather than at the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) schedule <= SCHEDULE_RESET;
      else        schedule <= decoded;
   end

endmodule

// File: tb/tb_gb_cpu_decoder.sv
// Randomized scoreboard bench for gb_cpu_decoder: a field-level reference model predicts
// each cycle's schedule and a monitor compares it one clock later.

module tb_gb_cpu_decoder;
   import gb_cpu_common_pkg::*;

   typedef struct {
      logic [26:0] exp;
      logic [9:0]  stim;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] opcode = 8'h00;
   logic       cb_prefix = 1'b0;
   logic       isr_cmd = 1'b0;
   schedule_t  schedule;

   item_t exp_q[$];
   int    passed = 0;
   int    total = 0;

   localparam logic [26:0] RESET_VAL = 27'h100_0000;

   gb_cpu_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .cb_prefix (cb_prefix),
      .isr_cmd   (isr_cmd),
      .schedule  (schedule)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: computes each field from the instruction-set rules, then packs.
   function automatic logic [26:0] model(input logic isr, input logic cb, input logic [7:0] op);
      int mc, alu, src, dst, rr, cbop, cbbit, rd, wr, imm, iscb, isisr, hlt, uns;
      int hi, mid, lo;
      logic [26:0] v;
      mc = 1; alu = 0; src = 0; dst = 0; rr = 0; cbop = 0; cbbit = 0;
      rd = 0; wr = 0; imm = 0; iscb = 0; isisr = 0; hlt = 0; uns = 0;
      hi  = int'(op) / 64;
      mid = (int'(op) / 8) % 8;
      lo  = int'(op) % 8;
      if (isr) begin
         mc = 5; wr = 1; isisr = 1; rr = 3;
      end else if (cb) begin
         alu = 15; iscb = 1; cbop = hi; cbbit = mid; src = lo; dst = lo;
         if (lo == 6) begin
            rd = 1;
            if (cbop == 1) mc = 2;
            else begin mc = 3; wr = 1; end
         end
      end else if (op == 8'h00) begin
         mc = 1;
      end else if (hi == 0 && (lo == 4 || lo == 5)) begin
         alu = (lo == 4) ? 9 : 10; src = mid; dst = mid;
         if (mid == 6) begin mc = 3; rd = 1; wr = 1; end
      end else if (hi == 0 && (int'(op) % 16 == 3 || int'(op) % 16 == 11 || int'(op) % 16 == 9)) begin
         mc = 2; rr = mid / 2;
         alu = (int'(op) % 16 == 3) ? 12 : (int'(op) % 16 == 11) ? 13 : 11;
      end else if (hi == 0 && lo == 6) begin
         imm = 1; dst = mid;
         if (mid == 6) begin mc = 3; wr = 1; end
         else mc = 2;
      end else if (op == 8'h76) begin
         hlt = 1;
      end else if (hi == 1) begin
         dst = mid; src = lo; rd = (lo == 6); wr = (mid == 6);
         if (lo == 6 || mid == 6) mc = 2;
      end else if (hi == 2) begin
         alu = mid + 1; dst = 7; src = lo;
         if (lo == 6) begin mc = 2; rd = 1; end
      end else if (hi == 3 && lo == 6) begin
         alu = mid + 1; dst = 7; mc = 2; imm = 1;
      end else if (op == 8'hE8) begin
         mc = 4; alu = 14; rr = 3; imm = 1;
      end else begin
         uns = 1;
      end
      v = {mc[2:0], alu[3:0], src[2:0], dst[2:0], rr[1:0], cbop[1:0], cbbit[2:0],
           rd[0], wr[0], imm[0], iscb[0], isisr[0], hlt[0], uns[0]};
      return v;
   endfunction

   task automatic drive(input logic isr, input logic cb, input logic [7:0] op);
      item_t it;
      @(negedge clk);
      isr_cmd   = isr;
      cb_prefix = cb;
      opcode    = op;
      it.exp    = model(isr, cb, op);
      it.stim   = {isr, cb, op};
      exp_q.push_back(it);
   endtask

   task automatic drive_random();
      logic isr, cb;
      isr = ($urandom_range(15) == 0);
      cb  = ($urandom_range(3) == 0);
      drive(isr, cb, 8'($urandom_range(255)));
   endtask

   // Monitor: the schedule is valid every cycle out of reset, one clock after its inputs.
   always @(posedge clk) begin
      item_t it;
      #1;
      if (rst_n && exp_q.size() > 0) begin
         it = exp_q.pop_front();
         check($sformatf("decode isr=%0b cb=%0b op=%02h", it.stim[9], it.stim[8], it.stim[7:0]),
               schedule, it.exp);
      end
   end

   logic [9:0] directed [15];

   initial begin
      directed = '{10'h0AB, 10'h015, 10'h034, 10'h033, 10'h00B, 10'h009, 10'h019, 10'h0E8,
                   10'h076, 10'h0D3, 10'h346, 10'h146, 10'h036, 10'h07E, 10'h000};

      // Reset held: schedule stays at its reset value whatever the inputs do.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         isr_cmd   = $urandom_range(1) == 1;
         cb_prefix = $urandom_range(1) == 1;
         opcode    = 8'($urandom_range(255));
         @(posedge clk);
         #1;
         check("reset_hold", schedule, RESET_VAL);
      end

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) drive(directed[i][9], directed[i][8], directed[i][7:0]);
      for (int i = 0; i < 400; i++) drive_random();

      // Mid-stream reset: output must drop to reset value before the next clock edge.
      @(negedge clk);
      opcode = 8'h34;
      isr_cmd = 1'b0;
      cb_prefix = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("async_reset", schedule, RESET_VAL);
      @(posedge clk);
      #1 check("reset_after_edge", schedule, RESET_VAL);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) drive_random();

      repeat (3) @(posedge clk);
      #2 check("scoreboard_drained", 27'(exp_q.size()), 27'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
